// File: rtl/gray_ram_pkg.sv
// Shared types, sizes and the Gray encoder for the runtime-built Gray table.
package gray_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 16;

    // Binary-reflected Gray code of an address, zero-extended to the word width.
    function automatic logic [RAM_DATA_W-1:0] gray_encode(input logic [RAM_ADDR_W-1:0] addr);
        logic [RAM_DATA_W-1:0] r;
        r = '0;
        r[RAM_ADDR_W-1:0] = addr ^ (addr >> 1);
        return r;
    endfunction

endpackage

// File: rtl/gray_ram_writer.sv
// Write-port driver for the 256x16 Gray table RAM: a start pulse fills every
// word with gray(i); afterwards a valid/ready host port patches single words.
// All RAM-side outputs are registered, so a write shown on ram_* after edge N
// is committed by the RAM at edge N+1.
module gray_ram_writer
    import gray_ram_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,   // must be >= ADDR_W
    parameter int FILL_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_wclke,
    output logic [DATA_W-1:0] ram_mask
);

    // Number of writes in one fill (2**ADDR_W), held one bit wider than an address.
    localparam logic [ADDR_W:0] FILL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;        // fill address, wraps modulo depth
    logic [ADDR_W:0]     nwr_q, nwr_d;        // writes issued so far in this fill
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   gray_cnt;

    // Use the shared encoder at the board's native geometry, an equivalent
    // width-generic expression otherwise.
    generate
        if (ADDR_W == RAM_ADDR_W && DATA_W == RAM_DATA_W) begin : g_pkg_gray
            assign gray_cnt = gray_encode(cnt_q);
        end else begin : g_generic_gray
            always_comb begin
                gray_cnt = '0;
                gray_cnt[ADDR_W-1:0] = cnt_q ^ (cnt_q >> 1);
            end
        end
    endgenerate

    // Host may only write outside a fill, and a start in the same cycle wins.
    assign wr_ready = (state_q != FILL) && !start;

    // Next-state logic: FSM, fill counter and the fill/host write mux.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nwr_d   = nwr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Arm the fill; the first word goes out on the next edge.
                    state_d = FILL;
                    cnt_d   = ADDR_W'(FILL_BASE);
                    nwr_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (wr_valid) begin
                    // wr_ready is high here since start is low.
                    we_d    = 1'b1;
                    waddr_d = wr_addr;
                    wdata_d = wr_data;
                end
            end
            FILL: begin
                // start is deliberately ignored: no restart, no extension.
                if (nwr_q == FILL_LEN) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = gray_cnt;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    nwr_d   = nwr_q + (ADDR_W+1)'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and registered RAM-side outputs; reset leaves RAM contents alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nwr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nwr_q   <= nwr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_we    = we_q;
    assign ram_wclke = we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign ram_mask  = '0;

endmodule

// File: tb/tb_gray_ram_writer.sv
// Bench for gray_ram_writer: a RAM model absorbs every write, a scoreboard
// queue holds the writes expected in order, and a table of read-back vectors
// checks the stored Gray words.
module tb_gray_ram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_wclke;
    logic [15:0] ram_mask;

    gray_ram_writer #(.ADDR_W(8), .DATA_W(16), .FILL_BASE(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_wclke (ram_wclke),
        .ram_mask  (ram_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  raddr;
        logic [15:0] exp_rdata;
    } vec_t;

    wr_t         exp_q[$];
    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gray_ref(input int i);
        return 16'((i & 255) ^ ((i & 255) >> 1));
    endfunction

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 8'(i), data: gray_ref(i)});
        end
    endtask

    task automatic scrub_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    endtask

    // Count table entries that do not hold the Gray code of their address.
    task automatic chk_table(input string name, input int lo, input int hi);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++) begin
            if (mem[i] !== gray_ref(i)) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    // RAM model plus scoreboard: a write on ram_* is committed at the next
    // edge, so sample between edges.
    always @(negedge clk) begin
        if (ram_we) begin
            wr_t e;
            wr_count++;
            mem[ram_waddr] = ram_wdata;
            chk("wclke_eq_we", {31'd0, ram_wclke}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_waddr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", {24'd0, ram_waddr}, {24'd0, e.addr});
                chk("sb_data", {16'd0, ram_wdata}, {16'd0, e.data});
            end
        end
    end

    vec_t vecs[7];

    initial begin
        int cyc;
        int busy_bad;
        int wr_base;

        vecs[0] = '{raddr: 8'h05, exp_rdata: 16'h0007};
        vecs[1] = '{raddr: 8'h80, exp_rdata: 16'h00C0};
        vecs[2] = '{raddr: 8'hFF, exp_rdata: 16'h0080};
        vecs[3] = '{raddr: 8'h10, exp_rdata: 16'h0018};
        vecs[4] = '{raddr: 8'hA5, exp_rdata: 16'h00F7};
        vecs[5] = '{raddr: 8'h00, exp_rdata: 16'h0000};
        vecs[6] = '{raddr: 8'h01, exp_rdata: 16'h0001};

        scrub_mem();
        rst = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_wclke", {31'd0, ram_wclke}, 32'd0);
        chk("rst_waddr", {24'd0, ram_waddr}, 32'd0);
        chk("rst_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("mask_zero", {16'd0, ram_mask}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'd0, wr_ready}, 32'd1);

        // Full fill from IDLE
        start = 1'b1;
        #1;
        chk("start_blocks_ready", {31'd0, wr_ready}, 32'd0);
        push_fill(256);
        wr_base = wr_count;
        tick();
        start = 1'b0;
        chk("fill_busy_first", {31'd0, busy}, 32'd1);
        chk("fill_no_we_first", {31'd0, ram_we}, 32'd0);
        cyc = 0;
        busy_bad = 0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
            if (!done && (!busy || wr_ready)) busy_bad++;
        end
        chk("fill_done_cycle", 32'(cyc), 32'd257);
        chk("fill_busy_hold", 32'(busy_bad), 32'd0);
        chk("fill_busy_end", {31'd0, busy}, 32'd0);
        chk("fill_we_end", {31'd0, ram_we}, 32'd0);
        chk("fill_write_count", 32'(wr_count - wr_base), 32'd256);
        chk("fill_sb_empty", 32'(exp_q.size()), 32'd0);
        chk_table("fill_table", 0, 255);
        for (int v = 0; v < 7; v++) begin
            chk($sformatf("rdata_%02h", vecs[v].raddr), {16'd0, mem[vecs[v].raddr]}, {16'd0, vecs[v].exp_rdata});
        end

        // Single host write in DONE
        wr_valid = 1'b1; wr_addr = 8'h3C; wr_data = 16'hBEEF;
        #1;
        chk("done_ready", {31'd0, wr_ready}, 32'd1);
        exp_q.push_back('{addr: 8'h3C, data: 16'hBEEF});
        wr_base = wr_count;
        tick();
        wr_valid = 1'b0;
        chk("host_we", {31'd0, ram_we}, 32'd1);
        chk("host_waddr", {24'd0, ram_waddr}, 32'h3C);
        chk("host_wdata", {16'd0, ram_wdata}, 32'hBEEF);
        chk("host_done_kept", {31'd0, done}, 32'd1);
        tick();
        chk("host_we_one_cycle", {31'd0, ram_we}, 32'd0);
        chk("host_write_count", 32'(wr_count - wr_base), 32'd1);
        chk("host_mem", {16'd0, mem[8'h3C]}, 32'hBEEF);

        // Host write held across start and the whole fill
        start = 1'b1; wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 16'h1234;
        #1;
        chk("start_vs_valid_ready", {31'd0, wr_ready}, 32'd0);
        push_fill(256);
        exp_q.push_back('{addr: 8'h20, data: 16'h1234});
        tick();
        start = 1'b0;
        chk("held_done_cleared", {31'd0, done}, 32'd0);
        cyc = 0;
        while (!wr_ready && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("held_ready_cycle", 32'(cyc), 32'd257);
        chk("held_done_at_ready", {31'd0, done}, 32'd1);
        tick();
        wr_valid = 1'b0;
        chk("held_we", {31'd0, ram_we}, 32'd1);
        chk("held_waddr", {24'd0, ram_waddr}, 32'h20);
        chk("held_wdata", {16'd0, ram_wdata}, 32'h1234);
        tick();
        chk("held_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("held_mem", {16'd0, mem[8'h20]}, 32'h1234);
        chk("refill_3c", {16'd0, mem[8'h3C]}, 32'h0022);

        // Start re-pulsed at write 50 must not restart or extend the fill
        scrub_mem();
        start = 1'b1;
        push_fill(256);
        wr_base = wr_count;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            start = (cyc == 50);
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("restart_done_cycle", 32'(cyc), 32'd257);
        chk("restart_write_count", 32'(wr_count - wr_base), 32'd256);
        chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);
        chk_table("restart_table", 0, 255);

        // Reset after 100 fill writes
        scrub_mem();
        start = 1'b1;
        push_fill(100);
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("pre_rst_waddr", {24'd0, ram_waddr}, 32'h63);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        tick();
        chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
        chk_table("midrst_partial", 0, 99);
        chk("midrst_untouched", {16'd0, mem[100]}, 32'hDEAD);
        start = 1'b1;
        push_fill(256);
        wr_base = wr_count;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("refill_done_cycle", 32'(cyc), 32'd257);
        chk("refill_write_count", 32'(wr_count - wr_base), 32'd256);
        chk_table("refill_table", 0, 255);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
